// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: MDU FSM encoding,
// the per-stage control bundle and the source-operand match helper.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;

  // Stage enables and bubble-inserts driven as one bundle.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam stage_ctrl_t CTRL_BRANCH = 7'b11111_11;
  localparam stage_ctrl_t CTRL_BUBBLE = 7'b00111_01;

  // True when a source operand the ID instruction actually reads matches dst.
  function automatic logic src_hit(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt,
    input logic [4:0] dst
  );
    return (uses_rs && (rs == dst)) || (uses_rt && (rt == dst));
  endfunction

endpackage

// File: rtl/pipe_mdu_timer.sv
// Countdown timer for the multi-cycle mult/div unit: loaded on start, counts down
// while the unit is active, and flags the final busy cycle.
module pipe_mdu_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             active,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (active && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign done = active && (cnt_reg == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: stage enables/flushes plus MDU scheduling.
// Optional perf counters are built only when PIPE_HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_mdu,
  input  logic        id_mdu_div,
  input  logic        id_rd_hilo,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_br_taken,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e  state_reg;
  mdu_state_e  state_next;
  stage_ctrl_t ctrl;
  logic        lu_haz;
  logic        mdu_haz;
  logic        timer_done;

  assign lu_haz  = ex_memread && (ex_rd != REG_ZERO) &&
                   src_hit(id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd);
  assign mdu_haz = (state_reg == MDU_BUSY) && (id_is_mdu || id_rd_hilo);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (mdu_start)  state_next = MDU_BUSY;
      MDU_BUSY: if (timer_done) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Priority: memory freeze, then branch flush, then hazard bubble. A start can
  // only come out of the lowest-priority arm, so a flushed ID slot never starts.
  always_comb begin
    ctrl      = CTRL_RUN;
    mdu_start = 1'b0;
    if (mem_wait) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_br_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (lu_haz || mdu_haz) begin
      ctrl = CTRL_BUBBLE;
    end else begin
      mdu_start = (state_reg == RUN) && id_is_mdu;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign mdu_busy   = (state_reg == MDU_BUSY);
  assign mdu_done   = timer_done;

  // The timer keeps counting through mem_wait: the MDU is not part of the frozen pipe.
  pipe_mdu_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (mdu_start),
    .active   (mdu_busy),
    .load_val (id_mdu_div ? DIV_LOAD : MUL_LOAD),
    .done     (timer_done)
  );

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_en)     stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (ifid_flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = NOP;
  assign flush_cnt = NOP;
`endif

endmodule
